hamming_enc_stream: RTL

- Streaming Hamming SEC encoder. Accepts DW-bit data words over a valid/ready handshake and emits each word together with its PW-bit parity, one pipeline stage later.
- Companion to hamming_dec. Its parity convention matches the decoder exactly, so hamming_dec on {o_data, o_parity} gives o_err_pos = 0 when no error has been injected.
- Includes a one-shot single-bit error injector and a word counter, used for in-system ECC path checks.

---
 rtl/hamming_pkg.sv | 38 +++
 rtl/hamming_parity_gen.sv | 28 ++
 rtl/hamming_enc_stream.sv | 103 ++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg
//   Shared Hamming SEC position map for hamming_enc_stream and hamming_dec.
//   Codeword positions run 1..TW. Power-of-two positions (2**k) carry parity
//   bit k. The other positions carry the data bits in ascending order, so
//   data bit 0 sits at position 3, data bit 1 at position 5, and so on.
//   Both the encoder and the decoder take the map from here, which keeps them
//   in agreement.
package hamming_pkg;

  // Default geometry. Modules carry their own DW/PW parameters.
  localparam int DEF_DW = 8;
  localparam int DEF_PW = 4;
  localparam int TW     = DEF_DW + DEF_PW;

  // Position table capacity. Each entry is 8 bits, so TW can be at most 255.
  localparam int MAX_DW = 64;
  typedef logic [MAX_DW-1:0][7:0] pos_arr_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Entry j is the codeword position that holds data bit j.
  function automatic pos_arr_t get_data_pos(input int dw, input int pw);
    pos_arr_t r;
    int       j;
    r = '0;
    j = 0;
    for (int p = 1; p <= dw + pw; p++) begin
      if (!is_pow2(p) && (j < dw) && (j < MAX_DW)) begin
        r[j[5:0]] = 8'(p);
        j++;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// hamming_parity_gen
//   Combinational Hamming parity generator. Parity bit k is the XOR of every
//   data bit whose codeword position has bit k set.
//   Ports:
//     data   - DW-bit data word
//     parity - PW-bit parity field
module hamming_parity_gen
  import hamming_pkg::*;
#(
  parameter int DW = 8,
  parameter int PW = 4
) (
  input  logic [DW-1:0] data,
  output logic [PW-1:0] parity
);

  localparam pos_arr_t DPOS = get_data_pos(DW, PW);

  always_comb begin
    parity = '0;
    for (int k = 0; k < PW; k++) begin
      for (int j = 0; j < DW; j++) begin
        if (DPOS[j][k]) parity[k] = parity[k] ^ data[j];
      end
    end
  end

endmodule

// File: rtl/hamming_enc_stream.sv
// hamming_enc_stream
//   Streaming Hamming SEC encoder. It has one output register, a one-shot
//   single-bit error injector and a counter of accepted words.
//   Ports:
//     i_clk, i_rst          - clock, synchronous active-high reset
//     i_valid/o_ready/i_data  - input word stream
//     o_valid/i_ready/o_data/o_parity - output codeword stream
//     i_inj_req, i_inj_pos  - arm a one-shot flip of codeword position 1..DW+PW
//     o_inj_armed           - injection pending
//     o_inj_done            - pulse on the first o_valid cycle of the flipped word
//     o_word_cnt            - accepted-word count (wraps)
//   Handshake: a word moves on any cycle where valid and ready are both high.
//   A producer holds valid and its data until that cycle. o_ready is
//   !o_valid || i_ready, which allows one word per cycle with a single
//   register stage. The parameters must satisfy 2**PW >= DW+PW+1.
module hamming_enc_stream
  import hamming_pkg::*;
#(
  parameter int DW = 8,
  parameter int PW = 4,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [PW-1:0] o_parity,
  input  logic          i_inj_req,
  input  logic [PW-1:0] i_inj_pos,
  output logic          o_inj_armed,
  output logic          o_inj_done,
  output logic [CW-1:0] o_word_cnt
);

  localparam pos_arr_t DPOS = get_data_pos(DW, PW);

  logic [PW-1:0] par;
  logic [PW-1:0] inj_pos;
  logic [DW-1:0] dflip;
  logic [PW-1:0] pflip;
  logic          accept;

  hamming_parity_gen #(.DW(DW), .PW(PW)) u_par (
    .data   (i_data),
    .parity (par)
  );

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;

  // Flip masks for the armed position. Position 0 and positions beyond
  // DW+PW match no bit, so those values consume the arm without a flip.
  always_comb begin
    dflip = '0;
    pflip = '0;
    if (o_inj_armed) begin
      for (int k = 0; k < PW; k++) begin
        if (int'(inj_pos) == (1 << k)) pflip[k] = 1'b1;
      end
      for (int j = 0; j < DW; j++) begin
        if (int'(inj_pos) == int'(DPOS[j])) dflip[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_parity    <= '0;
      o_inj_armed <= 1'b0;
      o_inj_done  <= 1'b0;
      o_word_cnt  <= '0;
      inj_pos     <= '0;
    end else begin
      o_inj_done <= 1'b0;
      if (accept) begin
        o_valid    <= 1'b1;
        o_data     <= i_data ^ dflip;
        o_parity   <= par ^ pflip;
        o_word_cnt <= o_word_cnt + CW'(1);
        if (o_inj_armed) begin
          o_inj_armed <= 1'b0;
          o_inj_done  <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      // The arm is tested against its registered value. A request that
      // arrives together with an accept while disarmed only arms, and a
      // request made while already armed is ignored.
      if (i_inj_req && !o_inj_armed) begin
        o_inj_armed <= 1'b1;
        inj_pos     <= i_inj_pos;
      end
    end
  end

endmodule
